tm1638_scan_ctrl: RTL

- Parametrised, continuously refreshing serial controller for TM1638 display/key boards: 8-bit segment digits, one discrete LED per digit, runtime brightness.
- Replaces the fixed-rate hex-only driver.
- Sits between the clock/counter logic and the board pins, with a programmable bit-clock divider and frame handshake.
- Raw segment patterns in; hex decode is upstream.

---
 rtl/tm1638_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_scan_ctrl.sv
// rtl/tm1638_scan_ctrl.sv - TM1638 continuous display refresh: commands, digit/LED data, brightness
// Optional key read phase after the display-control command: define TM1638_KEY_SCAN_EN.
module tm1638_scan_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int NUM_DIGITS = 8,
  parameter int FRAME_GAP  = 64,
  parameter int STB_GAP    = 4
) (
  input  logic                    clkinput,
  input  logic                    rst_n,
  input  logic [8*NUM_DIGITS-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]   led,
  input  logic                    display_on,
  input  logic [2:0]              brightness,
  input  logic                    hold,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    tm_clk,
  output logic                    tm_stb,
  output logic                    tm_dio_out,
  output logic                    tm_dio_oe,
  input  logic                    tm_dio_in,
  output logic [31:0]             keys,
  output logic                    keys_valid
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] DIV_HALF  = 16'(CLK_DIV);
  localparam logic [15:0] BIT_LAST  = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(FRAME_GAP - 1);
  localparam logic [15:0] STB_LAST  = 16'(STB_GAP - 1);
  localparam logic [3:0]  BYTE_LAST = 4'(2 * NUM_DIGITS - 1);
`ifdef TM1638_KEY_SCAN_EN
  localparam logic [15:0] WAIT_LAST = 16'(((2 * CLK_DIV > 4) ? 2 * CLK_DIV : 4) - 1);
`endif

  typedef enum logic [2:0] {GAP, CMD1, CMD2, DATA, CMD3, KEY, DONE} state_t;
  typedef enum logic [2:0] {S_LEAD, S_BITS, S_WAIT, S_READ, S_TRAIL} step_t;

  state_t state, state_d;
  step_t  step, step_d;
  logic [15:0] cnt, cnt_d;
  logic [4:0]  bit_idx, bit_d;
  logic [3:0]  byte_idx, byte_d, byte_nxt;
  logic [7:0]  shreg, sh_val, cmd_byte, data_nxt;
  logic        latch_en, sh_load, sh_shift;

  logic [8*NUM_DIGITS-1:0] seg_q;
  logic [NUM_DIGITS-1:0]   led_q;
  logic                    disp_q;
  logic [2:0]              bright_q;
  logic [63:0]             seg_pad;
  logic [7:0]              led_pad;

`ifdef TM1638_KEY_SCAN_EN
  logic        key_shift, key_commit;
  logic [31:0] key_sh, keys_q;
`endif

  // Zero-padded views keep the byte mux independent of NUM_DIGITS.
  always_comb begin
    seg_pad = '0;
    led_pad = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      seg_pad[8*k +: 8] = seg_q[8*k +: 8];
      led_pad[k]        = led_q[k];
    end
    byte_nxt = byte_idx + 4'd1;
    data_nxt = byte_nxt[0] ? {7'b0, led_pad[byte_nxt[3:1]]}
                           : seg_pad[{byte_nxt[3:1], 3'b000} +: 8];
    case (state)
      CMD1:    cmd_byte = 8'h40;
      CMD2:    cmd_byte = 8'hC0;
      KEY:     cmd_byte = 8'h42;
      default: cmd_byte = {4'b1000, disp_q, bright_q};
    endcase
  end

  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) begin
      state    <= GAP;
      step     <= S_LEAD;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_d;
      step     <= step_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      byte_idx <= byte_d;
    end
  end

  always_comb begin
    state_d  = state;
    step_d   = step;
    cnt_d    = cnt + 16'd1;
    bit_d    = bit_idx;
    byte_d   = byte_idx;
    latch_en = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_val   = cmd_byte;
`ifdef TM1638_KEY_SCAN_EN
    key_shift  = 1'b0;
    key_commit = 1'b0;
`endif
    case (state)
      GAP: begin
        // Counter saturates so a released hold starts the frame on the next edge.
        if (cnt >= GAP_LAST) begin
          cnt_d = cnt;
          if (!hold) begin
            latch_en = 1'b1;
            state_d  = CMD1;
            step_d   = S_LEAD;
            cnt_d    = '0;
          end
        end
      end
      DONE: begin
        state_d = GAP;
        step_d  = S_LEAD;
        cnt_d   = '0;
      end
      default: begin
        case (step)
          S_LEAD: begin
            if (cnt == DIV_LAST) begin
              step_d  = S_BITS;
              cnt_d   = '0;
              bit_d   = '0;
              sh_load = 1'b1;
            end
          end
          S_BITS: begin
            if (cnt == BIT_LAST) begin
              cnt_d = '0;
              if (bit_idx != 5'd7) begin
                bit_d    = bit_idx + 5'd1;
                sh_shift = 1'b1;
              end else begin
                bit_d = '0;
                case (state)
                  CMD2: begin
                    state_d = DATA;
                    byte_d  = '0;
                    sh_load = 1'b1;
                    sh_val  = seg_pad[7:0];
                  end
                  DATA: begin
                    if (byte_idx == BYTE_LAST) begin
                      step_d = S_TRAIL;
                    end else begin
                      byte_d  = byte_nxt;
                      sh_load = 1'b1;
                      sh_val  = data_nxt;
                    end
                  end
`ifdef TM1638_KEY_SCAN_EN
                  KEY:     step_d = S_WAIT;
`endif
                  default: step_d = S_TRAIL;
                endcase
              end
            end
          end
`ifdef TM1638_KEY_SCAN_EN
          S_WAIT: begin
            if (cnt == WAIT_LAST) begin
              step_d = S_READ;
              cnt_d  = '0;
              bit_d  = '0;
            end
          end
          S_READ: begin
            key_shift = (cnt == DIV_HALF);
            if (cnt == BIT_LAST) begin
              cnt_d = '0;
              if (bit_idx == 5'd31) step_d = S_TRAIL;
              else                  bit_d  = bit_idx + 5'd1;
            end
          end
`endif
          S_TRAIL: begin
            if (cnt == STB_LAST) begin
              cnt_d  = '0;
              step_d = S_LEAD;
              case (state)
                CMD1: state_d = CMD2;
                DATA: state_d = CMD3;
`ifdef TM1638_KEY_SCAN_EN
                CMD3: state_d = KEY;
                KEY: begin
                  state_d    = DONE;
                  key_commit = 1'b1;
                end
`endif
                default: state_d = DONE;
              endcase
            end
          end
          default: ;
        endcase
      end
    endcase
  end

  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) begin
      seg_q    <= '0;
      led_q    <= '0;
      disp_q   <= 1'b0;
      bright_q <= '0;
      shreg    <= '0;
    end else begin
      if (latch_en) begin
        seg_q    <= seg_data;
        led_q    <= led;
        disp_q   <= display_on;
        bright_q <= brightness;
      end
      if (sh_load)       shreg <= sh_val;
      else if (sh_shift) shreg <= {1'b0, shreg[7:1]};
    end
  end

  assign busy       = (state != GAP) && (state != DONE);
  assign frame_done = (state == DONE);
  assign tm_stb     = !busy || (step == S_TRAIL);
  assign tm_clk     = !(busy && (step == S_BITS || step == S_READ) && cnt < DIV_HALF);
  assign tm_dio_out = busy && (step == S_BITS) && shreg[0];

`ifdef TM1638_KEY_SCAN_EN
  always_ff @(posedge clkinput or negedge rst_n) begin
    if (!rst_n) begin
      key_sh <= '0;
      keys_q <= '0;
    end else begin
      if (key_shift)  key_sh <= {tm_dio_in, key_sh[31:1]};
      if (key_commit) keys_q <= key_sh;
    end
  end

  assign keys       = keys_q;
  assign keys_valid = frame_done;
  assign tm_dio_oe  = !(busy && (step == S_WAIT || step == S_READ));
`else
  logic unused_dio;
  assign unused_dio = tm_dio_in;
  assign keys       = '0;
  assign keys_valid = 1'b0;
  assign tm_dio_oe  = 1'b1;
`endif

endmodule
